// File: rtl/sal_axi_chan_agent.sv
// AXI address-channel master with B-channel sink and outstanding tracking.
// APB slave exposes CTRL (enable / counter clear), STATUS and traffic counters.
module sal_axi_chan_agent #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic [1:0]            req_burst,
  output logic                  avalid,
  input  logic                  aready,
  output logic [ID_WIDTH-1:0]   aid,
  output logic [ADDR_WIDTH-1:0] aaddr,
  output logic [7:0]            alen,
  output logic [2:0]            asize,
  output logic [1:0]            aburst,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  output logic                  rsp_valid,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [1:0]            rsp_resp,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [11:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr
);

  logic                  avalid_q, avalid_d;
  logic [ID_WIDTH-1:0]   aid_q, aid_d;
  logic [ADDR_WIDTH-1:0] aaddr_q, aaddr_d;
  logic [7:0]            alen_q, alen_d;
  logic [2:0]            asize_q, asize_d;
  logic [1:0]            aburst_q, aburst_d;
  logic [7:0]            outst_q, outst_d;
  logic                  en_q, en_d;
  logic [31:0]           issued_q, issued_d, done_q, done_d, err_q, err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic       a_hs, b_hs, req_hs;
  logic [8:0] pending;
  logic       apb_acc, apb_hit, apb_ro, ctrl_wr, clr;
  logic [31:0] rd_val;
  logic       unused_pwdata;

  assign unused_pwdata = ^pwdata[31:2];

  always_comb begin
    a_hs    = avalid_q & aready;
    bready  = (outst_q != 8'd0);
    b_hs    = bvalid & bready;
    // A pending beat already counts against the outstanding limit.
    pending = {1'b0, outst_q} + {8'd0, avalid_q};
    req_ready = en_q & (~avalid_q | aready) & (pending < 9'(MAX_OUTSTANDING));
    req_hs  = req_valid & req_ready;

    apb_acc = psel & penable;
    apb_hit = 1'b1;
    apb_ro  = 1'b1;
    rd_val  = 32'd0;
    case (paddr)
      12'h000: begin rd_val = {31'd0, en_q}; apb_ro = 1'b0; end
      12'h004: rd_val = {23'd0, avalid_q, outst_q};
      12'h008: rd_val = issued_q;
      12'h00C: rd_val = done_q;
      12'h010: rd_val = err_q;
      default: apb_hit = 1'b0;
    endcase
    pready  = 1'b1;
    pslverr = apb_acc & (~apb_hit | (pwrite & apb_ro));
    prdata  = (apb_acc && !pslverr) ? rd_val : 32'd0;
    ctrl_wr = apb_acc & pwrite & ~pslverr & (paddr == 12'h000);
    clr     = ctrl_wr & pwdata[1];
    en_d    = ctrl_wr ? pwdata[0] : en_q;

    avalid_d = avalid_q;
    aid_d    = aid_q;
    aaddr_d  = aaddr_q;
    alen_d   = alen_q;
    asize_d  = asize_q;
    aburst_d = aburst_q;
    if (req_hs) begin
      avalid_d = 1'b1;
      aid_d    = req_id;
      aaddr_d  = req_addr;
      alen_d   = req_len;
      asize_d  = req_size;
      aburst_d = req_burst;
    end else if (a_hs) begin
      avalid_d = 1'b0;
    end

    outst_d = outst_q;
    if (a_hs && !b_hs) outst_d = outst_q + 8'd1;
    else if (!a_hs && b_hs) outst_d = outst_q - 8'd1;

    // Clear wins over a coincident count event.
    issued_d = clr ? 32'd0 : issued_q + {31'd0, a_hs};
    done_d   = clr ? 32'd0 : done_q + {31'd0, b_hs};
    err_d    = clr ? 32'd0 : err_q + {31'd0, b_hs & bresp[1]};

    rsp_valid_d = b_hs;
    rsp_id_d    = b_hs ? bid : rsp_id_q;
    rsp_resp_d  = b_hs ? bresp : rsp_resp_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avalid_q    <= 1'b0;
      aid_q       <= '0;
      aaddr_q     <= '0;
      alen_q      <= '0;
      asize_q     <= '0;
      aburst_q    <= '0;
      outst_q     <= '0;
      en_q        <= 1'b1;
      issued_q    <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_resp_q  <= '0;
    end else begin
      avalid_q    <= avalid_d;
      aid_q       <= aid_d;
      aaddr_q     <= aaddr_d;
      alen_q      <= alen_d;
      asize_q     <= asize_d;
      aburst_q    <= aburst_d;
      outst_q     <= outst_d;
      en_q        <= en_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign avalid    = avalid_q;
  assign aid       = aid_q;
  assign aaddr     = aaddr_q;
  assign alen      = alen_q;
  assign asize     = asize_q;
  assign aburst    = aburst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_sal_axi_chan_agent.sv
// Directed bench for sal_axi_chan_agent: inputs change on negedge, outputs
// are checked 1ns later, well away from the active posedge.
module tb_sal_axi_chan_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic        avalid, aready;
  logic [3:0]  aid;
  logic [31:0] aaddr;
  logic [7:0]  alen;
  logic [2:0]  asize;
  logic [1:0]  aburst;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        rsp_valid;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic        err;
  int          n_acc;

  always #5 clk = ~clk;

  sal_axi_chan_agent #(.ID_WIDTH(4), .ADDR_WIDTH(32), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .avalid(avalid), .aready(aready), .aid(aid), .aaddr(aaddr), .alen(alen),
    .asize(asize), .aburst(aburst),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] v, output logic e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
    @(negedge clk); penable = 1'b1;
    #1 e = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_id = '0; req_addr = '0; req_len = '0;
    req_size = '0; req_burst = '0; aready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_avalid", 32'(avalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pready", 32'(pready), 32'd1);
    chk("idle_prdata", prdata, 32'd0);

    // First beat, all-zero fields, slave ready
    @(negedge clk); req_valid = 1'b1; aready = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    #1;
    chk("t1_avalid", 32'(avalid), 32'd1);
    chk("t1_aaddr", aaddr, 32'd0);
    chk("t1_alen", 32'(alen), 32'd0);
    @(negedge clk); #1;
    chk("t1_avalid_drop", 32'(avalid), 32'd0);
    chk("t1_bready", 32'(bready), 32'd1);
    apb_rd(12'h004, rd, err); chk("t1_status", rd, 32'h001);
    apb_rd(12'h008, rd, err); chk("t1_issued", rd, 32'd1);

    // Backpressure on the address channel
    @(negedge clk); req_valid = 1'b1; req_id = 4'd2; req_addr = 32'h1000;
    req_len = 8'd3; req_size = 3'd2; req_burst = 2'd1; aready = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_avalid_hold", 32'(avalid), 32'd1);
      chk("t2_aaddr_hold", aaddr, 32'h1000);
      chk("t2_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    chk("t2_fields", {19'd0, aid, alen, asize, aburst}, {19'd0, 4'd2, 8'd3, 3'd2, 2'd1});
    aready = 1'b1;
    #1 chk("t2_req_ready_same", 32'(req_ready), 32'd1);
    @(negedge clk); #1 chk("t2_accepted", 32'(avalid), 32'd0);

    // Two responses, out of order ids, second is an error
    @(negedge clk); bvalid = 1'b1; bid = 4'd1; bresp = 2'd0;
    @(negedge clk); bvalid = 1'b0;
    #1 chk("t3_rsp1", {27'd0, rsp_valid, rsp_id, rsp_resp}, {27'd0, 1'b1, 4'd1, 2'd0});
    @(negedge clk);
    #1 chk("t3_rsp1_pulse", 32'(rsp_valid), 32'd0);
    bvalid = 1'b1; bid = 4'd0; bresp = 2'd2;
    @(negedge clk); bvalid = 1'b0;
    #1 chk("t3_rsp2", {27'd0, rsp_valid, rsp_id, rsp_resp}, {27'd0, 1'b1, 4'd0, 2'd2});
    apb_rd(12'h00C, rd, err); chk("t3_done", rd, 32'd2);
    apb_rd(12'h010, rd, err); chk("t3_err", rd, 32'd1);
    apb_rd(12'h004, rd, err); chk("t3_status", rd, 32'd0);
    @(negedge clk); bvalid = 1'b1;
    @(negedge clk); bvalid = 1'b0;
    #1 chk("t3_b_ignored", 32'(rsp_valid), 32'd0);
    chk("t3_bready0", 32'(bready), 32'd0);

    // Fill to the outstanding limit
    @(negedge clk); req_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      #1 if (req_ready) n_acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("t4_accepted", 32'(n_acc), 32'd8);
    #1 chk("t4_req_ready_full", 32'(req_ready), 32'd0);
    apb_rd(12'h004, rd, err); chk("t4_status", rd, 32'd8);
    @(negedge clk); bvalid = 1'b1; bid = 4'd3; bresp = 2'd0;
    @(negedge clk); bvalid = 1'b0;
    #1 chk("t4_req_ready_free", 32'(req_ready), 32'd1);
    apb_rd(12'h008, rd, err); chk("t4_issued", rd, 32'd10);

    // Drain to 3, then simultaneous A and B handshakes
    @(negedge clk); bvalid = 1'b1;
    repeat (4) @(negedge clk);
    bvalid = 1'b0;
    apb_rd(12'h004, rd, err); chk("t5_status3", rd, 32'd3);
    @(negedge clk); req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0; bvalid = 1'b1;
    #1 chk("t5_both_pending", {30'd0, avalid, bready}, 32'd3);
    @(negedge clk); bvalid = 1'b0;
    apb_rd(12'h004, rd, err); chk("t5_status_same", rd, 32'd3);
    apb_rd(12'h008, rd, err); chk("t5_issued", rd, 32'd11);
    apb_rd(12'h00C, rd, err); chk("t5_done", rd, 32'd8);

    // APB control, clear and error paths
    apb_wr(12'h000, 32'h2, err); chk("t6_ctrl_wr_err", 32'(err), 32'd0);
    apb_rd(12'h008, rd, err); chk("t6_issued_clr", rd, 32'd0);
    apb_rd(12'h00C, rd, err); chk("t6_done_clr", rd, 32'd0);
    apb_rd(12'h010, rd, err); chk("t6_err_clr", rd, 32'd0);
    apb_rd(12'h000, rd, err); chk("t6_ctrl_rd", rd, 32'd0);
    #1 chk("t6_req_ready_dis", 32'(req_ready), 32'd0);
    apb_wr(12'h008, 32'h55, err); chk("t6_ro_wr_err", 32'(err), 32'd1);
    apb_rd(12'h020, rd, err);
    chk("t6_unmapped_err", 32'(err), 32'd1);
    chk("t6_unmapped_data", rd, 32'd0);
    apb_wr(12'h004, 32'hFF, err); chk("t6_status_wr_err", 32'(err), 32'd1);
    apb_rd(12'h004, rd, err); chk("t6_status_kept", rd, 32'd3);
    apb_wr(12'h000, 32'h1, err);
    apb_rd(12'h000, rd, err); chk("t6_ctrl_en", rd, 32'd1);

    // Reset mid-burst with a pending beat and outstanding transactions
    @(negedge clk); aready = 1'b0; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    #1 chk("t7_pending", 32'(avalid), 32'd1);
    rst = 1'b1; bvalid = 1'b1;
    @(negedge clk); rst = 1'b0; bvalid = 1'b0;
    #1 chk("t7_rst_state", {29'd0, avalid, bready, rsp_valid}, 32'd0);
    apb_rd(12'h004, rd, err); chk("t7_status", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
